sdnet_to_mtpsa: RTL and testbench
=================================

// Module: sdnet_to_mtpsa
// PURPOSE
//  Output-side adapter of an SDNet user pipeline (e.g. user5Switch). Complements mtpsa_to_sdnet on the input side.
//  Captures the one-cycle tuple_out metadata + digest pulses into a small tuple FIFO.
//  Re-aligns them to the outgoing packet stream and drives SUME m_axis_tuser, held constant for every beat of the packet.
//  Adds packet/drop counters and a sticky metadata/digest mismatch flag for debug.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   256  packet TDATA width; TKEEP = /8
//  C_META_WIDTH        40   mtpsa metadata tuple width
//  DIGEST_WIDTH        256  digest tuple width
//  TUPLE_FIFO_DEPTH    4    tuple FIFO entries; power of 2, >=2
// PORTS
//  axis_aclk              in   1    single clock
//  axis_resetn            in   1    synchronous, active-low reset
//  sdnet_tvalid           in   1    SDNet packet_out TVALID
//  sdnet_tready           out  1    SDNet packet_out TREADY
//  sdnet_tdata            in   DW   SDNet packet_out TDATA
//  sdnet_tkeep            in   DW/8 SDNet packet_out TKEEP
//  sdnet_tlast            in   1    SDNet packet_out TLAST
//  meta_valid             in   1    tuple_out_mtpsa_metadata_VALID, 1-cycle pulse per packet
//  meta_data              in   MW   tuple_out_mtpsa_metadata_DATA
//  digest_valid           in   1    tuple_out_digest_data_VALID
//  digest_data            in   DGW  tuple_out_digest_data_DATA
//  m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  SUME packet output
//  m_axis_tuser           out  DGW+MW  {digest, meta}
//  pkt_count              out  32   packets completed on m_axis
//  tuple_drop_count       out  16   tuples lost to FIFO overflow; saturating
//  err_tuple_mismatch     out  1    sticky: meta_valid != digest_valid in some cycle
// BEHAVIOUR
//  - Reset (axis_resetn=0 at clock edge):
//    FIFO emptied; state=SOP; counters=0; err=0.
//    m_axis_tvalid=0, sdnet_tready=0 from the next cycle.
//    Reset mid-packet abandons the packet; no partial-packet recovery.
//  - Push: meta_valid=1 and FIFO not full -> write {digest_data, meta_data}.
//    digest_data is sampled in the same cycle even if digest_valid=0.
//  - Overflow: meta_valid=1 and FIFO full with no pop in that cycle -> tuple discarded; tuple_drop_count+1, sat at 0xFFFF.
//    Full with a pop in the same cycle -> push accepted (count unchanged).
//  - Mismatch: meta_valid != digest_valid in any cycle -> err_tuple_mismatch=1 until reset.
//  - Head visibility: a pushed entry is visible at the head 1 cycle after the push. There is no write->read bypass.
//  - Data path is combinational pass-through (0-cycle latency) of tdata/tkeep/tlast, gated by h = FIFO not empty:
//    m_axis_tvalid = sdnet_tvalid & h; sdnet_tready = m_axis_tready & h.
//    m_axis_tuser = FIFO head, held for all beats of the packet.
//  - Beat = m_axis_tvalid & m_axis_tready.
//  - FSM: SOP --beat & !tlast--> IN_PKT; IN_PKT --beat & tlast--> SOP; SOP --beat & tlast--> SOP (1-beat packet).
//  - Pop on a beat with tlast; pkt_count+1 in the same cycle, wrapping at 2^32.
//  - Head entry is never changed mid-packet. Pops occur only on the tlast beat.
//  - Empty FIFO stalls the stream: tready=0 and tvalid=0, with no combinational dependency of tvalid on tready.
//  - AXIS rule: once m_axis_tvalid=1 it is held with stable data until accepted. This holds because h can only drop on a pop.
//  - m_axis_tuser is don't-care while m_axis_tvalid=0, but is driven from the head register, never X after reset.
// STRUCTURE
//  - Package sdnet_mtpsa_pkg holds:
//    width constants (META/DIGEST/TUSER);
//    tuser field offsets: pkt_len[15:0], src_port[23:16], dst_port[31:24], send_dig_to_cpu[39:32];
//    FSM state enum {SOP, IN_PKT}.
//  - One sub-module: sdnet_tuple_fifo.
//    Synchronous registered-output FIFO, width DGW+MW, depth TUPLE_FIFO_DEPTH.
//    Ports: push/pop/full/empty/head; ptrs with extra wrap bit.
//  - Top holds the FSM, gating, counters and the error flag.
// TESTING
//  1. Single packet, 3 beats: meta_valid pulse with meta=0x01_04_01_0040, digest=0xAB.. two cycles before the first beat
//     -> 3 beats out, tuser={0xAB..,0x0104010040} on every beat, pkt_count=1.
//  2. Data before tuple: sdnet_tvalid=1 for 5 cycles with FIFO empty, then meta_valid
//     -> tready/tvalid low until 1 cycle after the push, then the packet flows.
//  3. Back-to-back 1-beat packets, 4 tuples queued, m_axis_tready toggling 1010
//     -> 4 packets out, each with its own tuser in order, no duplicate or skipped tuple.
//  4. Overflow: push 5 tuples with no packets (depth 4) -> tuple_drop_count=1; the first 4 tuples are emitted in order.
//  5. Full + pop + push in the same cycle on the tlast beat -> push accepted, drop count unchanged.
//  6. Mismatch/reset: digest_valid without meta_valid -> err=1.
//     Reset asserted mid-packet -> next cycle all outputs 0, FIFO empty; a fresh packet afterwards passes normally.

Source files
------------

// File: rtl/sdnet_mtpsa_pkg.sv
// Shared widths, tuser field layout and packet-tracking state for the SDNet output adapter.
package sdnet_mtpsa_pkg;

    localparam int DATA_W     = 256;
    localparam int META_W     = 40;
    localparam int DGST_W     = 256;
    localparam int TUSER_W    = DGST_W + META_W;
    localparam int FIFO_DEPTH = 4;

    // Field positions inside the metadata part of m_axis_tuser
    localparam int PKT_LEN_LSB  = 0;
    localparam int PKT_LEN_MSB  = 15;
    localparam int SRC_PORT_LSB = 16;
    localparam int SRC_PORT_MSB = 23;
    localparam int DST_PORT_LSB = 24;
    localparam int DST_PORT_MSB = 31;
    localparam int SEND_DIG_LSB = 32;
    localparam int SEND_DIG_MSB = 39;

    typedef enum logic {
        SOP    = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/sdnet_tuple_fifo.sv
// Tuple FIFO with pointer wrap bits; head is read straight from the storage registers.
// The caller only pushes when not full or when popping in the same cycle.
module sdnet_tuple_fifo #(
    parameter int WIDTH = 296,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/sdnet_to_mtpsa.sv
// SDNet packet_out to SUME adapter: queues per-packet tuples and presents the head tuple
// as m_axis_tuser for every beat of the matching packet, with debug counters.
module sdnet_to_mtpsa
    import sdnet_mtpsa_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = DATA_W,
    parameter int C_META_WIDTH      = META_W,
    parameter int DIGEST_WIDTH      = DGST_W,
    parameter int TUPLE_FIFO_DEPTH  = FIFO_DEPTH
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic                                 sdnet_tvalid,
    output logic                                 sdnet_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]         sdnet_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]       sdnet_tkeep,
    input  logic                                 sdnet_tlast,
    input  logic                                 meta_valid,
    input  logic [C_META_WIDTH-1:0]              meta_data,
    input  logic                                 digest_valid,
    input  logic [DIGEST_WIDTH-1:0]              digest_data,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic [DIGEST_WIDTH+C_META_WIDTH-1:0] m_axis_tuser,
    output logic [31:0]                          pkt_count,
    output logic [15:0]                          tuple_drop_count,
    output logic                                 err_tuple_mismatch
);

    localparam int TW = DIGEST_WIDTH + C_META_WIDTH;

    logic       w_empty;
    logic       w_full;
    logic       w_h;
    logic       w_beat;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    pkt_state_e r_state;
    pkt_state_e w_state_nxt;
    logic [31:0] r_pkt_count;
    logic [15:0] r_drop_count;
    logic        r_err;

    // A full FIFO still accepts a tuple when the head leaves in the same cycle
    assign w_h    = !w_empty;
    assign w_beat = m_axis_tvalid & m_axis_tready;
    assign w_pop  = w_beat & sdnet_tlast;
    assign w_push = meta_valid & (!w_full | w_pop);
    assign w_drop = meta_valid & w_full & !w_pop;

    sdnet_tuple_fifo #(
        .WIDTH (TW),
        .DEPTH (TUPLE_FIFO_DEPTH)
    ) u_tuple_fifo (
        .i_clk    (axis_aclk),
        .i_resetn (axis_resetn),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wdata  ({digest_data, meta_data}),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head   (m_axis_tuser)
    );

    assign m_axis_tvalid = sdnet_tvalid & w_h;
    assign sdnet_tready  = m_axis_tready & w_h;
    assign m_axis_tdata  = sdnet_tdata;
    assign m_axis_tkeep  = sdnet_tkeep;
    assign m_axis_tlast  = sdnet_tlast;

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_state <= SOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SOP:     if (w_beat && !sdnet_tlast) w_state_nxt = IN_PKT;
            IN_PKT:  if (w_beat && sdnet_tlast)  w_state_nxt = SOP;
            default: w_state_nxt = SOP;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_pop) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (meta_valid != digest_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pkt_count          = r_pkt_count;
    assign tuple_drop_count   = r_drop_count;
    assign err_tuple_mismatch = r_err;

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Directed and randomized bench for sdnet_to_mtpsa against a queue-based reference model.
module tb_sdnet_to_mtpsa;

    localparam int DW = 256;
    localparam int MW = 40;
    localparam int GW = 256;
    localparam int TW = GW + MW;

    logic          axis_aclk;
    logic          axis_resetn;
    logic          sdnet_tvalid;
    logic          sdnet_tready;
    logic [DW-1:0] sdnet_tdata;
    logic [DW/8-1:0] sdnet_tkeep;
    logic          sdnet_tlast;
    logic          meta_valid;
    logic [MW-1:0] meta_data;
    logic          digest_valid;
    logic [GW-1:0] digest_data;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [TW-1:0] m_axis_tuser;
    logic [31:0]   pkt_count;
    logic [15:0]   tuple_drop_count;
    logic          err_tuple_mismatch;

    sdnet_to_mtpsa dut (
        .axis_aclk          (axis_aclk),
        .axis_resetn        (axis_resetn),
        .sdnet_tvalid       (sdnet_tvalid),
        .sdnet_tready       (sdnet_tready),
        .sdnet_tdata        (sdnet_tdata),
        .sdnet_tkeep        (sdnet_tkeep),
        .sdnet_tlast        (sdnet_tlast),
        .meta_valid         (meta_valid),
        .meta_data          (meta_data),
        .digest_valid       (digest_valid),
        .digest_data        (digest_data),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tuser       (m_axis_tuser),
        .pkt_count          (pkt_count),
        .tuple_drop_count   (tuple_drop_count),
        .err_tuple_mismatch (err_tuple_mismatch)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: queued tuples in arrival order plus counters
    logic [TW-1:0] tq[$];
    logic [31:0]   exp_pkt  = '0;
    logic [15:0]   exp_drop = '0;
    logic          exp_err  = 1'b0;
    bit            last_beat;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [MW-1:0] rnd_meta();
        logic [MW-1:0] v;
        v = {8'($urandom), 32'($urandom)};
        return v;
    endfunction

    function automatic logic [GW-1:0] rnd_dig();
        logic [GW-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Check outputs mid-cycle, advance the model across the next rising edge
    task automatic tick();
        bit h, beat, pop, full;
        #4;
        h = (tq.size() != 0);
        chk("tvalid", TW'(m_axis_tvalid), TW'(sdnet_tvalid & h));
        chk("tready", TW'(sdnet_tready), TW'(m_axis_tready & h));
        chk("tdata", TW'(m_axis_tdata), TW'(sdnet_tdata));
        chk("tkeep", TW'(m_axis_tkeep), TW'(sdnet_tkeep));
        chk("tlast", TW'(m_axis_tlast), TW'(sdnet_tlast));
        if (h) chk("tuser", m_axis_tuser, tq[0]);
        chk("pkt_count", TW'(pkt_count), TW'(exp_pkt));
        chk("drop_count", TW'(tuple_drop_count), TW'(exp_drop));
        chk("err", TW'(err_tuple_mismatch), TW'(exp_err));
        beat = sdnet_tvalid && h && m_axis_tready;
        pop  = beat && sdnet_tlast;
        last_beat = beat;
        if (!axis_resetn) begin
            tq.delete();
            exp_pkt  = '0;
            exp_drop = '0;
            exp_err  = 1'b0;
        end else begin
            full = (tq.size() == 4);
            if (meta_valid) begin
                if (!full || pop) tq.push_back({digest_data, meta_data});
                else if (exp_drop != 16'hFFFF) exp_drop++;
            end
            if (pop) begin
                void'(tq.pop_front());
                exp_pkt++;
            end
            if (meta_valid != digest_valid) exp_err = 1'b1;
        end
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic push_tuple(input logic [MW-1:0] m, input logic [GW-1:0] d);
        meta_valid   = 1'b1;
        digest_valid = 1'b1;
        meta_data    = m;
        digest_data  = d;
        tick();
        meta_valid   = 1'b0;
        digest_valid = 1'b0;
        meta_data    = rnd_meta();
        digest_data  = rnd_dig();
    endtask

    // mode: 0 = tready high, 1 = tready 1010..., 2 = random tready
    task automatic send_pkt(input int n, input int mode, input bit push_on_last, input bit rand_push);
        int  sent = 0;
        int  cyc  = 0;
        bit  done = 0;
        sdnet_tvalid = 1'b1;
        sdnet_tdata  = rnd_dig();
        sdnet_tkeep  = $urandom;
        sdnet_tlast  = (n == 1);
        while (!done && cyc < 300) begin
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ((cyc % 2) == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            meta_valid   = 1'b0;
            digest_valid = 1'b0;
            if (push_on_last && sdnet_tlast && m_axis_tready) begin
                meta_valid   = 1'b1;
                digest_valid = 1'b1;
                meta_data    = rnd_meta();
                digest_data  = rnd_dig();
            end else if (rand_push && $urandom_range(0, 3) == 0) begin
                meta_valid   = 1'b1;
                digest_valid = 1'b1;
                meta_data    = rnd_meta();
                digest_data  = rnd_dig();
            end
            tick();
            cyc++;
            if (last_beat) begin
                sent++;
                if (sent == n) begin
                    done = 1;
                end else begin
                    sdnet_tdata = rnd_dig();
                    sdnet_tkeep = $urandom;
                    sdnet_tlast = (sent == n - 1);
                end
            end
        end
        sdnet_tvalid  = 1'b0;
        sdnet_tlast   = 1'b0;
        meta_valid    = 1'b0;
        digest_valid  = 1'b0;
        m_axis_tready = 1'b1;
        chk("pkt_done", TW'(done), TW'(1));
    endtask

    initial begin
        axis_resetn   = 1'b0;
        sdnet_tvalid  = 1'b0;
        sdnet_tdata   = '0;
        sdnet_tkeep   = '0;
        sdnet_tlast   = 1'b0;
        meta_valid    = 1'b0;
        meta_data     = '0;
        digest_valid  = 1'b0;
        digest_data   = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #1;
        tick();
        tick();
        axis_resetn = 1'b1;
        tick();

        // 1: single 3-beat packet, tuple two cycles ahead
        push_tuple(40'h01_04_01_0040, {32{8'hAB}});
        tick();
        send_pkt(3, 0, 0, 0);
        tick();
        chk("t1_pkt_count", TW'(pkt_count), TW'(1));

        // 2: data waits for its tuple
        sdnet_tvalid = 1'b1;
        sdnet_tdata  = rnd_dig();
        repeat (5) tick();
        push_tuple(rnd_meta(), rnd_dig());
        send_pkt(2, 0, 0, 0);

        // 3: four queued 1-beat packets, tready toggling
        repeat (4) push_tuple(rnd_meta(), rnd_dig());
        repeat (4) send_pkt(1, 1, 0, 0);
        tick();
        chk("t3_pkt_count", TW'(pkt_count), TW'(6));

        // 4: overflow by one tuple
        repeat (5) push_tuple(rnd_meta(), rnd_dig());
        tick();
        chk("t4_drop", TW'(tuple_drop_count), TW'(1));
        repeat (4) send_pkt(1, 0, 0, 0);

        // 5: full FIFO, push coincides with the popping tlast beat
        repeat (4) push_tuple(rnd_meta(), rnd_dig());
        send_pkt(2, 0, 1, 0);
        repeat (4) send_pkt(1, 0, 0, 0);
        tick();
        chk("t5_drop", TW'(tuple_drop_count), TW'(1));

        // 6: mismatch, then reset in the middle of a packet
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        tick();
        chk("t6_err", TW'(err_tuple_mismatch), TW'(1));
        push_tuple(rnd_meta(), rnd_dig());
        sdnet_tvalid = 1'b1;
        sdnet_tlast  = 1'b0;
        sdnet_tdata  = rnd_dig();
        tick();
        axis_resetn = 1'b0;
        tick();
        axis_resetn = 1'b1;
        tick();
        chk("t6_tvalid_after_rst", TW'(m_axis_tvalid), TW'(0));
        sdnet_tvalid = 1'b0;
        push_tuple(rnd_meta(), rnd_dig());
        send_pkt(3, 2, 0, 0);

        // randomized traffic with concurrent tuple arrivals
        for (int it = 0; it < 25; it++) begin
            int np;
            int idle;
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) push_tuple(rnd_meta(), rnd_dig());
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) tick();
            if (tq.size() != 0) send_pkt($urandom_range(1, 4), $urandom_range(0, 2), 0, 1);
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
